// File: rtl/uart_pkt_pkg.sv
// Shared types and helpers for the UART packet receive controller.
package uart_pkt_pkg;

  typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHK, DRAIN} state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // Checksum accumulation is a plain 8-bit wrapping add.
  function automatic logic [7:0] chk_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: synchronous write, asynchronous read.
module uart_pkt_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [DEPTH-1:0][7:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_pkt_rx_ctrl.sv
// Packet receive controller: SOF hunt, length-prefixed capture, checksum
// validation and valid/ready release of clean payloads.
module uart_pkt_rx_ctrl
  import uart_pkt_pkg::*;
#(
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 2560,
  parameter logic [7:0] SOF_BYTE     = SOF_DEFAULT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] rx_data_i,
  input  logic       rx_done_i,
  output logic [7:0] m_data_o,
  output logic       m_valid_o,
  input  logic       m_ready_i,
  output logic       m_last_o,
  output logic       busy_o,
  output logic       pkt_ok_o,
  output logic       chk_err_o,
  output logic       len_err_o,
  output logic       timeout_o,
  output logic       overrun_o
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  state_t        state, state_nx;
  logic [CW-1:0] len_q, wr_ptr, rd_ptr;
  logic [7:0]    sum_q, rd_data;
  logic [TW-1:0] tmr;
  logic          active, expire, len_ok, sum_ok, last, hs;
  logic          ok_nx, ce_nx, le_nx, to_nx, ov_nx;

  assign active = (state == LEN) || (state == PAYLOAD) || (state == CHK);
  // A byte on the expiry cycle takes priority over the timeout.
  assign expire = active && !rx_done_i && (tmr == TW'(TIMEOUT_CLKS - 1));
  assign len_ok = (rx_data_i != 8'd0) && (int'(rx_data_i) <= MAX_LEN);
  assign sum_ok = (chk_add(sum_q, rx_data_i) == 8'd0);
  assign last   = (rd_ptr == len_q - CW'(1));
  assign hs     = (state == DRAIN) && m_ready_i;

  always_comb begin
    state_nx = state;
    ok_nx    = 1'b0;
    ce_nx    = 1'b0;
    le_nx    = 1'b0;
    to_nx    = 1'b0;
    ov_nx    = 1'b0;
    case (state)
      HUNT:    if (rx_done_i && rx_data_i == SOF_BYTE) state_nx = LEN;
      LEN:     if (rx_done_i) begin
                 if (len_ok) state_nx = PAYLOAD;
                 else begin le_nx = 1'b1; state_nx = HUNT; end
               end
      PAYLOAD: if (rx_done_i && (wr_ptr + CW'(1) == len_q)) state_nx = CHK;
      CHK:     if (rx_done_i) begin
                 if (sum_ok) begin ok_nx = 1'b1; state_nx = DRAIN; end
                 else begin ce_nx = 1'b1; state_nx = HUNT; end
               end
      DRAIN:   begin
                 ov_nx = rx_done_i;
                 if (hs && last) state_nx = HUNT;
               end
      default: state_nx = HUNT;
    endcase
    if (expire) begin
      to_nx    = 1'b1;
      state_nx = HUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= HUNT;
      tmr       <= '0;
      len_q     <= '0;
      sum_q     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pkt_ok_o  <= 1'b0;
      chk_err_o <= 1'b0;
      len_err_o <= 1'b0;
      timeout_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      state     <= state_nx;
      pkt_ok_o  <= ok_nx;
      chk_err_o <= ce_nx;
      len_err_o <= le_nx;
      timeout_o <= to_nx;
      overrun_o <= ov_nx;
      tmr       <= (rx_done_i || !active || expire) ? '0 : tmr + TW'(1);
      case (state)
        LEN:     if (rx_done_i && len_ok) begin
                   len_q  <= rx_data_i[CW-1:0];
                   sum_q  <= rx_data_i;
                   wr_ptr <= '0;
                 end
        PAYLOAD: if (rx_done_i) begin
                   wr_ptr <= wr_ptr + CW'(1);
                   sum_q  <= chk_add(sum_q, rx_data_i);
                 end
        CHK:     if (rx_done_i && sum_ok) rd_ptr <= '0;
        DRAIN:   if (hs) rd_ptr <= rd_ptr + CW'(1);
        default: ;
      endcase
    end
  end

  uart_pkt_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (state == PAYLOAD && rx_done_i),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (rx_data_i),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

  assign m_valid_o = (state == DRAIN);
  assign m_data_o  = m_valid_o ? rd_data : 8'd0;
  assign m_last_o  = m_valid_o && last;
  assign busy_o    = (state != HUNT);

endmodule

// File: tb/tb_uart_pkt_rx_ctrl.sv
// Randomized + directed bench for uart_pkt_rx_ctrl with a frame-level scoreboard.
module tb_uart_pkt_rx_ctrl;

  localparam int ML = 16;
  localparam int TO = 48;

  logic       clk = 1'b0, resetn = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_done = 1'b0, m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_valid, m_last, busy, pkt_ok, chk_err, len_err, timeout, overrun;

  uart_pkt_rx_ctrl #(.MAX_LEN(ML), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .resetn(resetn), .rx_data_i(rx_data), .rx_done_i(rx_done),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready), .m_last_o(m_last),
    .busy_o(busy), .pkt_ok_o(pkt_ok), .chk_err_o(chk_err), .len_err_o(len_err),
    .timeout_o(timeout), .overrun_o(overrun)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int n_ok = 0, n_ce = 0, n_le = 0, n_to = 0, n_ov = 0;
  int b_ok, b_ce, b_le, b_to, b_ov;
  int e_ok, e_ce, e_le, e_to, e_ov;
  logic [7:0] got_d[$];
  logic       got_l[$];
  logic [7:0] frm[$];
  int         gap[$];
  logic [7:0] exp_q[$];
  bit         rdy_rand = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [19:0] pk(input int a, input int b, input int c, input int d, input int e);
    return {4'(a), 4'(b), 4'(c), 4'(d), 4'(e)};
  endfunction

  // Stream/pulse monitor, sampled mid-cycle.
  initial begin
    logic       p_stall = 1'b0, p_valid = 1'b0, p_last = 1'b0;
    logic [7:0] p_data = 8'd0;
    logic [4:0] p_pulse = 5'd0, cur;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        p_stall = 1'b0; p_valid = 1'b0; p_pulse = 5'd0;
      end else begin
        cur = {pkt_ok, chk_err, len_err, timeout, overrun};
        if (pkt_ok)  n_ok++;
        if (chk_err) n_ce++;
        if (len_err) n_le++;
        if (timeout) n_to++;
        if (overrun) n_ov++;
        if (m_valid && m_ready) begin got_d.push_back(m_data); got_l.push_back(m_last); end
        if (p_stall) chk("hold", {m_valid, m_last, m_data}, {1'b1, p_last, p_data});
        if (m_valid && !p_valid) chk("vld_rise", 32'(pkt_ok), 32'd1);
        if (p_pulse != 5'd0) chk("pulse_w", 32'(p_pulse & cur), 32'd0);
        p_stall = m_valid && !m_ready;
        p_valid = m_valid; p_last = m_last; p_data = m_data; p_pulse = cur;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic idle(input int n); repeat (n) tick(); endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_done = 1'b1; tick(); rx_done = 1'b0;
  endtask

  task automatic push(input logic [7:0] b, input int g);
    frm.push_back(b); gap.push_back(g);
  endtask

  task automatic snap();
    got_d.delete(); got_l.delete(); frm.delete(); gap.delete(); exp_q.delete();
    b_ok = n_ok; b_ce = n_ce; b_le = n_le; b_to = n_to; b_ov = n_ov;
    e_ok = 0; e_ce = 0; e_le = 0; e_to = 0; e_ov = 0;
  endtask

  task automatic play();
    foreach (frm[i]) begin send_byte(frm[i]); idle(gap[i]); end
  endtask

  function automatic int rgap();
    return ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 3));
  endfunction

  // Appends SOF, LEN, payload, CHK; bad != 0 corrupts the checksum.
  task automatic mk_frame(input int len, input bit bad);
    int s = len;
    logic [7:0] b;
    push(8'hA5, rgap()); push(8'(len), rgap());
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom); s += b; exp_q.push_back(b); push(b, rgap());
    end
    b = 8'((256 - (s % 256)) % 256);
    if (bad) b = b + 8'($urandom_range(1, 255));
    push(b, 0);
    if (bad) begin exp_q.delete(); e_ce = 1; end
    else e_ok = 1;
  endtask

  task automatic settle(input string tag);
    int k = 0;
    while ((busy || m_valid) && k < 2000) begin
      m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      tick(); k++;
    end
    if (k >= 2000) chk({tag, "_idle"}, 32'd1, 32'd0);
    m_ready = 1'b1;
    idle(2);
    chk({tag, "_pulses"}, 32'(pk(n_ok - b_ok, n_ce - b_ce, n_le - b_le, n_to - b_to, n_ov - b_ov)),
        32'(pk(e_ok, e_ce, e_le, e_to, e_ov)));
    chk({tag, "_len"}, 32'(got_d.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_d.size(); i++)
      chk({tag, "_byte"}, {23'd0, got_l[i], got_d[i]}, {23'd0, (i == exp_q.size() - 1), exp_q[i]});
  endtask

  initial begin
    logic [7:0] nb;
    int kind, len, p;
    idle(3);
    chk("rst", {m_valid, m_last, busy, pkt_ok, chk_err, len_err, timeout, overrun, m_data}, 32'd0);
    resetn = 1'b1; tick();

    // Good frame.
    snap(); push(8'hA5,0); push(8'h03,0); push(8'h11,0); push(8'h22,0); push(8'h33,0); push(8'h97,0);
    exp_q = '{8'h11, 8'h22, 8'h33}; e_ok = 1; play(); settle("good");

    // Bad checksum.
    snap(); push(8'hA5,0); push(8'h03,0); push(8'h11,0); push(8'h22,0); push(8'h33,0); push(8'h96,0);
    e_ce = 1; play(); settle("badchk");

    // Length errors.
    snap(); push(8'hA5,0); push(8'h00,0); e_le = 1; play(); settle("len0");
    snap(); push(8'hA5,0); push(8'h11,0); e_le = 1; play(); settle("len17");

    // Noise before a good frame.
    snap(); push(8'h00,0); push(8'hFF,1); push(8'h5A,0);
    push(8'hA5,0); push(8'h03,0); push(8'h11,0); push(8'h22,0); push(8'h33,0); push(8'h97,0);
    exp_q = '{8'h11, 8'h22, 8'h33}; e_ok = 1; play(); settle("noise");

    // Backpressure with an SOF byte injected during DRAIN.
    snap(); push(8'hA5,0); push(8'h03,0); push(8'h11,0); push(8'h22,0); push(8'h33,0); push(8'h97,0);
    exp_q = '{8'h11, 8'h22, 8'h33}; e_ok = 1; e_ov = 1;
    m_ready = 1'b0; play();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {m_valid, m_data}, {1'b1, 8'h11});
      if (i == 2) send_byte(8'hA5); else tick();
    end
    m_ready = 1'b1; settle("bp");

    // Timeout exactly TO idle cycles after the last byte.
    snap(); push(8'hA5,0); push(8'h02,0); push(8'h11,0); play();
    idle(TO - 1);
    chk("to_pre", {busy, timeout}, {1'b1, 1'b0});
    tick();
    chk("to_hit", {busy, timeout}, {1'b0, 1'b1});
    e_to = 1; settle("to");

    // Bytes landing on the expiry cycle keep the frame alive.
    snap(); push(8'hA5,TO-1); push(8'h02,TO-1); push(8'h11,TO-1); push(8'h22,TO-1); push(8'hCB,0);
    exp_q = '{8'h11, 8'h22}; e_ok = 1; play(); settle("to_edge");

    // Reset mid-payload, then a clean frame.
    snap(); push(8'hA5,0); push(8'h05,0); push(8'h11,0); push(8'h22,0); play();
    resetn = 1'b0; tick();
    chk("rst_mid", {m_valid, m_last, busy, pkt_ok, chk_err, len_err, timeout, overrun, m_data}, 32'd0);
    resetn = 1'b1; tick();
    snap(); push(8'hA5,0); push(8'h03,0); push(8'h11,0); push(8'h22,0); push(8'h33,0); push(8'h97,0);
    exp_q = '{8'h11, 8'h22, 8'h33}; e_ok = 1; play(); settle("post_rst");

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      snap();
      rdy_rand = 1'($urandom_range(0, 1));
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
        nb = 8'($urandom); if (nb == 8'hA5) nb = 8'h00; push(nb, int'($urandom_range(0, 2)));
      end
      kind = int'($urandom_range(0, 3));
      case (kind)
        0, 1: mk_frame(int'($urandom_range(1, ML)), kind == 1);
        2: begin
          len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(ML + 1, 255));
          push(8'hA5, rgap()); push(8'(len), 0); e_le = 1;
        end
        default: begin
          len = int'($urandom_range(1, ML));
          p = int'($urandom_range(0, len + 1));
          mk_frame(len, 1'b0);
          exp_q.delete(); e_ok = 0;
          while (frm.size() > 0 && frm[frm.size() - 1] != 8'hA5 && p < len + 2) begin
            void'(frm.pop_back()); void'(gap.pop_back()); p++;
          end
          void'(gap.pop_back()); gap.push_back(TO + 2); e_to = 1;
        end
      endcase
      play(); settle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_pkt_rx_ctrl.md
# uart_pkt_rx_ctrl

Packet-level receive controller placed directly behind `uart_rx`. It consumes the per-byte `done`/data outputs and hunts for a start-of-frame byte. It then collects a length-prefixed payload into an internal buffer and validates an 8-bit additive checksum. Only checksum-clean payloads are released, as a valid/ready byte stream with a last marker; malformed, corrupt or stalled frames are dropped and flagged.

## Interface
- `MAX_LEN`, 16: maximum payload bytes per packet; buffer depth; ≥1.
- `TIMEOUT_CLKS`, 2560: inter-byte gap limit in clk cycles, about two byte times at 128 clocks/bit.
- `SOF_BYTE`, 8'hA5: start-of-frame marker.
- `clk`  in  1  clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `rx_data_i`  in  8  received byte; valid when `rx_done_i`=1.
- `rx_done_i`  in  1  one-cycle pulse per received byte.
- `m_data_o`  out  8  payload byte.
- `m_valid_o`  out  1  `m_data_o` valid.
- `m_ready_i`  in  1  downstream accepts the byte.
- `m_last_o`  out  1  final payload byte of the packet.
- `busy_o`  out  1  high in every state except HUNT.
- `pkt_ok_o`  out  1  pulse: checksum passed.
- `chk_err_o`  out  1  pulse: checksum failed.
- `len_err_o`  out  1  pulse: LEN=0 or LEN>MAX_LEN.
- `timeout_o`  out  1  pulse: gap exceeded mid-frame.
- `overrun_o`  out  1  pulse: byte arrived during DRAIN and was dropped.

## Operation
- Frame format: SOF, LEN, LEN payload bytes, CHK. The frame is valid when (LEN + Σpayload + CHK) mod 256 = 0.
- All internal sums are 8-bit and wrap. Counters are `$clog2(MAX_LEN+1)` bits wide.
- HUNT: bytes other than `SOF_BYTE` are ignored. An SOF byte moves the FSM to LEN.
- LEN: if the byte is in 1..MAX_LEN, store it, load the running sum with it, clear `wr_ptr`, and go to PAYLOAD. Otherwise pulse `len_err_o` and return to HUNT.
- PAYLOAD: write each byte to `buf[wr_ptr]`, increment `wr_ptr`, and add the byte to the sum. When `wr_ptr` reaches LEN, go to CHK.
- CHK: if sum+byte == 0, pulse `pkt_ok_o`, clear `rd_ptr`, and go to DRAIN. Otherwise pulse `chk_err_o` and go to HUNT.
- DRAIN: `m_valid_o`=1 and `m_data_o`=`buf[rd_ptr]`. `m_last_o`=1 when `rd_ptr`=LEN-1. On a handshake, `rd_ptr` increments; a handshake with `m_last_o` returns the FSM to HUNT.
- During DRAIN, every `rx_done_i` pulses `overrun_o` and the byte is discarded. This includes an SOF byte: there is no re-hunt until HUNT is re-entered.
- Gap timer:
  - Clears on every `rx_done_i` and runs only in LEN, PAYLOAD and CHK.
  - On reaching TIMEOUT_CLKS-1 without a byte: pulse `timeout_o` and go to HUNT.
  - If `rx_done_i` arrives on the same cycle the timer expires, the byte wins and no timeout occurs.
- Reset mid-operation abandons any frame in progress. No stream output appears after reset; buffer contents are don't-care.

## Timing
- Reset values: `m_data_o`=0 (don't-care while `m_valid_o`=0); `m_valid_o`, `m_last_o`, `busy_o` and all pulse outputs = 0; FSM in HUNT.
- Each `rx_done_i` is processed in the cycle it is sampled. The state change and any pulse are visible on the next clock edge.
- `m_valid_o` rises one cycle after the CHK byte is sampled, in the same cycle as the `pkt_ok_o` pulse.
- Throughput in DRAIN is one byte per cycle when `m_ready_i`=1.
- While `m_valid_o`=1 and `m_ready_i`=0, `m_data_o` and `m_last_o` hold stable. `m_valid_o` never drops before its handshake.
- After the last handshake, `m_valid_o`=0 and the FSM is in HUNT on the next cycle. A byte arriving that same next cycle is parsed normally.
- Every pulse output is exactly one cycle wide.

## Structure
- Package `uart_pkt_pkg` holds:
  - the state encoding: HUNT, LEN, PAYLOAD, CHK, DRAIN;
  - the `SOF_BYTE` default;
  - the checksum-add function.
- One sub-module, `uart_pkt_buf`: a MAX_LEN×8 register array with a synchronous write port and an asynchronous read port addressed by `rd_ptr`.
- The FSM, gap timer and pointers live in the top level.

## Test plan
- Good frame: A5 03 11 22 33 97. Expect `pkt_ok_o` pulse, then stream 11, 22, 33 with `m_last_o` on 33.
- Bad checksum: A5 03 11 22 33 96. Expect a `chk_err_o` pulse and `m_valid_o` never high.
- Length errors:
  - A5 00 gives a `len_err_o` pulse.
  - A5 11 (MAX_LEN=16) gives a `len_err_o` pulse.
  - Noise bytes 00 FF 5A before a good frame are ignored; the good frame is accepted.
- Backpressure: good frame with `m_ready_i`=0 for 5 cycles at the first byte. Expect `m_data_o`=11 held stable. A byte injected during DRAIN gives an `overrun_o` pulse and the stream is unaltered.
- Timeout: A5 02 11, then silence for TIMEOUT_CLKS cycles. Expect a `timeout_o` pulse and a return to HUNT. A byte landing exactly on the expiry cycle gives no timeout. A subsequent good frame passes.
- Reset: assert `resetn`=0 mid-PAYLOAD. Expect all outputs 0 and `busy_o`=0; the next full frame is received correctly.
